// File: rtl/wb_master_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states, one-hot
// grant codes and the bus data width.
package wb_master_arbiter_pkg;

   localparam int WB_DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_GRANT0 = 2'd1,
      ARB_GRANT1 = 2'd2
   } arbState_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_M0   = 2'b01;
   localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_master_arbiter_watchdog.sv
// Stall watchdog: counts strobed, un-acked slave cycles and flags the cycle in
// which the count reaches WATCHDOG_CYCLES.
module wb_arb_watchdog #(
   parameter int WATCHDOG_CYCLES = 1024
) (
   input  logic clk,
   input  logic rstN,
   input  logic stall,
   input  logic grantRel,
   output logic err
);

   logic [15:0] cnt;

   // cnt holds the number of earlier stalled cycles, so err fires in the Nth one
   assign err = stall && (cnt == 16'(WATCHDOG_CYCLES - 1));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN)
         cnt <= '0;
      else if (!stall || err || grantRel)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter, round-robin on ties, grant held for a whole CYC.
// Optional stall watchdog enabled by defining WB_ARB_WATCHDOG_EN.
module wb_master_arbiter
   import wb_master_arbiter_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 24,
   parameter int WATCHDOG_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic [ADDRESS_WIDTH-1:0] m0AdrI,
   input  logic [ADDRESS_WIDTH-1:0] m1AdrI,
   input  logic [WB_DATA_WIDTH-1:0] m0DatI,
   input  logic [WB_DATA_WIDTH-1:0] m1DatI,
   input  logic                     m0CycI,
   input  logic                     m0StbI,
   input  logic                     m0WeI,
   input  logic                     m1CycI,
   input  logic                     m1StbI,
   input  logic                     m1WeI,
   output logic [WB_DATA_WIDTH-1:0] m0DatO,
   output logic [WB_DATA_WIDTH-1:0] m1DatO,
   output logic                     m0AckO,
   output logic                     m1AckO,
   output logic                     m0ErrO,
   output logic                     m1ErrO,
   output logic [ADDRESS_WIDTH-1:0] sAdrO,
   output logic [WB_DATA_WIDTH-1:0] sDatO,
   output logic                     sCycO,
   output logic                     sStbO,
   output logic                     sWeO,
   input  logic [WB_DATA_WIDTH-1:0] sDatI,
   input  logic                     sAckI,
   output logic [1:0]               grantO
);

   arbState_t  state;
   logic [1:0] grant;
   logic [1:0] lastGrant;
   logic       rawCyc;
   logic       rawStb;
   logic       wdErr;

`ifdef WB_ARB_WATCHDOG_EN
   logic grantRel;

   assign grantRel = (grant[0] & ~m0CycI) | (grant[1] & ~m1CycI);

   // stall is taken before the error-cycle suppression to avoid a feedback path
   wb_arb_watchdog #(
      .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
   ) uWatchdog (
      .clk      (clk),
      .rstN     (rstN),
      .stall    (rawCyc & rawStb & ~sAckI),
      .grantRel (grantRel),
      .err      (wdErr)
   );
`else
   assign wdErr = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= ARB_IDLE;
         grant     <= GRANT_NONE;
         lastGrant <= GRANT_M1;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (m0CycI && (!m1CycI || lastGrant == GRANT_M1)) begin
                  state <= ARB_GRANT0;
                  grant <= GRANT_M0;
               end else if (m1CycI) begin
                  state <= ARB_GRANT1;
                  grant <= GRANT_M1;
               end
            end
            ARB_GRANT0: begin
               if (!m0CycI || wdErr) begin
                  lastGrant <= GRANT_M0;
                  state     <= m1CycI ? ARB_GRANT1 : ARB_IDLE;
                  grant     <= m1CycI ? GRANT_M1 : GRANT_NONE;
               end
            end
            ARB_GRANT1: begin
               if (!m1CycI || wdErr) begin
                  lastGrant <= GRANT_M1;
                  state     <= m0CycI ? ARB_GRANT0 : ARB_IDLE;
                  grant     <= m0CycI ? GRANT_M0 : GRANT_NONE;
               end
            end
            default: begin
               state <= ARB_IDLE;
               grant <= GRANT_NONE;
            end
         endcase
      end
   end

   always_comb begin
      rawCyc = 1'b0;
      rawStb = 1'b0;
      sAdrO  = '0;
      sDatO  = '0;
      sWeO   = 1'b0;
      if (grant[0]) begin
         rawCyc = m0CycI;
         rawStb = m0StbI;
         sAdrO  = m0AdrI;
         sDatO  = m0DatI;
         sWeO   = m0WeI;
      end else if (grant[1]) begin
         rawCyc = m1CycI;
         rawStb = m1StbI;
         sAdrO  = m1AdrI;
         sDatO  = m1DatI;
         sWeO   = m1WeI;
      end
   end

   assign sCycO  = rawCyc & ~wdErr;
   assign sStbO  = rawCyc & rawStb & ~wdErr;
   assign m0DatO = sDatI;
   assign m1DatO = sDatI;
   assign m0AckO = sAckI & grant[0];
   assign m1AckO = sAckI & grant[1];
   assign m0ErrO = wdErr & grant[0];
   assign m1ErrO = wdErr & grant[1];
   assign grantO = grant;

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single 16-bit Wishbone slave bus (register space 0x00000-0x0FFFF, program space 0x10000-0x1FFFF) between the test Processor (master 0) and the host loader/debug master (master 1).
- Grant is held for a whole bus cycle (while the granted master keeps CYC high).
- Ties are resolved round-robin.
- Sits between the masters and the address decoder/slave mux.

Parameters:
- ADDRESS_WIDTH, 24, width of all Wishbone address buses.
- WATCHDOG_CYCLES, 1024, stall limit used only when WB_ARB_WATCHDOG_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstN  in  1  asynchronous, active-low reset.
- m0AdrI, m1AdrI  in  ADDRESS_WIDTH  master address.
- m0DatI, m1DatI  in  16  master write data.
- m0CycI, m0StbI, m0WeI, m1CycI, m1StbI, m1WeI  in  1 each  master cycle/strobe/write-enable.
- m0DatO, m1DatO  out  16  read data, both driven from sDatI.
- m0AckO, m1AckO  out  1 each  ack, routed to the granted master only.
- m0ErrO, m1ErrO  out  1 each  error termination (watchdog only; otherwise constant 0).
- sAdrO  out  ADDRESS_WIDTH  slave address.
- sDatO  out  16  slave write data.
- sCycO, sStbO, sWeO  out  1 each  slave cycle/strobe/write-enable.
- sDatI  in  16  slave read data.
- sAckI  in  1  slave ack.
- grantO  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle.

Behaviour:
- Reset (rstN low, asynchronous): state = IDLE, grant = 00, lastGrant = m1 (so m0 wins the first tie), watchdog counter = 0.
  - All s* outputs, m*AckO and m*ErrO read 0 while grant = 00.
- States: IDLE, GRANT0, GRANT1; state is registered.
- IDLE transitions:
  - only m0CycI -> GRANT0; only m1CycI -> GRANT1.
  - both -> the master that is NOT lastGrant.
  - none -> stay IDLE.
- GRANTx transitions:
  - while mxCycI = 1, stay; no preemption, not even mid-burst.
  - when mxCycI = 0: lastGrant <= x; go to GRANTy if the other master's CycI = 1, else IDLE.
  - Handover is therefore back-to-back with no dead cycle.
- Latency: a request raised in cycle N reaches the slave in cycle N+1 when the bus is free. Arbitration costs exactly 1 cycle.
- Output mux (combinational from registered grant):
  - sAdrO/sDatO/sWeO = granted master's values, else 0.
  - sCycO = granted CycI; sStbO = granted CycI & StbI.
  - mxAckO = sAckI & grant[x].
  - Non-granted master sees AckO = 0 and may hold CYC/STB indefinitely.
- Ack and CYC drop in the same cycle: the transfer completes to the current master, then the release rule applies on the next edge.
- Slave ack while grant = 00 is ignored (dropped).
- Master asserting STB without CYC is ignored.
- Reset asserted mid-cycle: the bus is released immediately (asynchronously); no ack is issued afterwards.

Optional Feature:
- Macro: WB_ARB_WATCHDOG_EN.
- Defined:
  - 16-bit counter counts cycles where sCycO & sStbO & !sAckI; it clears on ack, on grant change, or when STB drops.
  - On reaching WATCHDOG_CYCLES: pulse mxErrO for 1 cycle to the granted master, force the grant to release on the next edge (as if CYC dropped), and suppress sCycO/sStbO during the error cycle.
- Undefined: no counter is present; m0ErrO/m1ErrO are tied to 0.

Decomposition:
- Shared package holds:
  - state encodings ARB_IDLE=0, ARB_GRANT0=1, ARB_GRANT1=2;
  - grant one-hot constants;
  - the 16-bit Wishbone data-width constant.
- One sub-module, wb_arb_watchdog (counter + compare, error pulse output), instantiated only under WB_ARB_WATCHDOG_EN.

Test Plan:
- Single master: m0 reads 0x10000 with slave ack after 2 wait states -> sCycO rises 1 cycle after m0CycI; m0AckO pulses once; m0DatO = sDatI = 0x0001; m1AckO stays 0.
- Tie after reset: m0 and m1 raise CYC in the same cycle -> grantO = 01. After m0 drops CYC, grantO = 10 on the very next cycle with no idle gap.
- Round-robin: both masters continuously re-request single transfers -> grants alternate 01, 10, 01, 10 over 4 cycles. No master receives 2 consecutive grants while the other waits.
- Locked burst: m0 holds CYC over 5 acked transfers to 0x00000-0x00004 while m1 requests -> m1 sees no ack and grantO stays 01 until m0 releases.
- Async reset mid-transfer: rstN pulsed low between clock edges during m1 write (sWeO=1, sAdrO=0x00010) -> all s* outputs 0 immediately; grantO = 00; after reset, the first tie goes to m0.
- Watchdog (macro defined, WATCHDOG_CYCLES=8): slave never acks m0 -> m0ErrO pulses exactly at the 8th stalled cycle; grant released; pending m1 granted on the following cycle. With the macro undefined, the bus stalls indefinitely.
